// File: rtl/rx_byte_fifo.sv
// Receive-side byte FIFO for a UART: turns each rising edge of the receiver's
// valid level into one 9-bit push {parity_error, byte}, presented first-word-fall-through.
module rx_byte_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            received_data,
  input  logic                  data_is_valid,
  input  logic                  rx_error,
  output logic [7:0]            rd_data,
  output logic                  rd_error,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  full,
  output logic                  overflow,
  input  logic                  overflow_clear
);

  // Read side: an entry moves when rd_valid && rd_ready at a clk edge;
  // rd_data/rd_error are stable and meaningful only while rd_valid is 1.

  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  logic                  dv_q, dv_d;
  logic                  armed_q, armed_d;
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [8:0]            mem_q [DEPTH];

  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  full_w;
  logic                  wr_en;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_w = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  // armed_q keeps a valid level already high at reset release from counting as an edge.
  assign push  = armed_q && data_is_valid && !dv_q;
  assign pop   = !empty && rd_ready;
  assign wr_en = push && (!full_w || pop);

  always_comb begin
    dv_d     = data_is_valid;
    armed_d  = 1'b1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && full_w && !pop) ovf_d = 1'b1;
    else if (overflow_clear)    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dv_q     <= 1'b0;
      armed_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      dv_q     <= dv_d;
      armed_q  <= armed_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately not reset; rd_valid gates its use.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= {rx_error, received_data};
  end

  assign rd_data    = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]][7:0];
  assign rd_error   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]][8];
  assign rd_valid   = !empty;
  assign full       = full_w;
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Bench for rx_byte_fifo: directed scenarios followed by random traffic, all
// compared each cycle against a queue-based model of the FIFO's rules.
module tb_rx_byte_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          reset_n;
  logic [7:0]    received_data;
  logic          data_is_valid;
  logic          rx_error;
  logic [7:0]    rd_data;
  logic          rd_error;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW:0]   fifo_count;
  logic          full;
  logic          overflow;
  logic          overflow_clear;

  rx_byte_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .received_data  (received_data),
    .data_is_valid  (data_is_valid),
    .rx_error       (rx_error),
    .rd_data        (rd_data),
    .rd_error       (rd_error),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .fifo_count     (fifo_count),
    .full           (full),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [8:0] exp_q[$];
  bit         exp_ovf;
  bit         prev_dv;
  bit         armed;

  int tests;
  int failed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
    check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    check("full", 32'(full), 32'(exp_q.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    if (exp_q.size() != 0) begin
      check("rd_data", 32'(rd_data), 32'(exp_q[0][7:0]));
      check("rd_error", 32'(rd_error), 32'(exp_q[0][8]));
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
    prev_dv = 1'b0;
    armed   = 1'b0;
  endtask

  // One clock edge of the FIFO rules, evaluated on the pre-edge contents.
  task automatic model_edge();
    bit push_req, pop_ok, drop;
    push_req = armed && (data_is_valid === 1'b1) && !prev_dv;
    pop_ok   = (exp_q.size() != 0) && (rd_ready === 1'b1);
    drop     = push_req && (exp_q.size() == DEPTH) && !pop_ok;
    if (pop_ok) void'(exp_q.pop_front());
    if (push_req && !drop) exp_q.push_back({rx_error, received_data});
    if (drop) exp_ovf = 1'b1;
    else if (overflow_clear === 1'b1) exp_ovf = 1'b0;
    prev_dv = (data_is_valid === 1'b1);
    armed   = 1'b1;
  endtask

  // driver
  task automatic step(input logic dv, input logic [7:0] d, input logic e,
                      input logic rdy, input logic clr);
    data_is_valid  = dv;
    received_data  = d;
    rx_error       = e;
    rd_ready       = rdy;
    overflow_clear = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic push_byte(input logic [7:0] d, input logic e);
    step(1'b1, d, e, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    data_is_valid = 1'b0;
    received_data = 8'h00;
    rx_error = 1'b0;
    rd_ready = 1'b0;
    overflow_clear = 1'b0;
    model_reset();
    apply_reset();

    // single byte, one-cycle latency, pop
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("a5_valid", 32'(rd_valid), 32'd1);
    check("a5_data", 32'(rd_data), 32'hA5);
    check("a5_count", 32'(fifo_count), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("a5_popped", 32'(rd_valid), 32'd0);

    // long valid level yields one entry
    for (int i = 0; i < 5; i++) step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("hold_count", 32'(fifo_count), 32'd1);
    drain();

    // fill, overflow, drain in order, then second fill across the pointer wrap
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b0);
    push_byte(8'h10, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 32'(rd_data), 32'(i));
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i), 1'b0);
    drain();

    // push while full with simultaneous pop
    for (int i = 0; i < DEPTH; i++) push_byte(8'h40 + 8'(i), 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    check("fullpop_count", 32'(fifo_count), 32'd16);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("last_55", 32'(rd_data), 32'h55);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // parity error flag, and overflow set beating overflow_clear
    step(1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
    check("err_flag", 32'(rd_error), 32'd1);
    check("err_data", 32'(rd_data), 32'h81);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) push_byte(8'(i), 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    check("set_wins", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);
    drain();

    // asynchronous reset with 7 entries stored
    for (int i = 0; i < 7; i++) push_byte(8'h60 + 8'(i), 1'b0);
    check("pre_rst_count", 32'(fifo_count), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_valid", 32'(rd_valid), 32'd0);
    check("async_count", 32'(fifo_count), 32'd0);
    check("async_ovf", 32'(overflow), 32'd0);

    // valid already high at release: no push
    data_is_valid = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check("no_push_release", 32'(fifo_count), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    check("push_after_release", 32'(fifo_count), 32'd1);
    drain();

    // random traffic: slow consumer phase, then fast consumer phase
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001: Parameter DEPTH, default 16, sets the number of byte entries; it SHALL be a power of two and at least 2.
REQ-002: Parameter ADDR_WIDTH, default 4, is the pointer width and SHALL equal log2(DEPTH).
REQ-003: clk  input  1  single clock for all logic.
REQ-004: reset_n  input  1  asynchronous active-low reset.
REQ-005: received_data  input  8  parallel byte from the UART receiver.
REQ-006: data_is_valid  input  1  receiver valid level; it may stay high for more than one cycle per byte.
REQ-007: rx_error  input  1  receiver parity-error flag, qualified by data_is_valid.
REQ-008: rd_data  output  8  byte at the FIFO head.
REQ-009: rd_error  output  1  parity-error flag stored with rd_data.
REQ-010: rd_valid  output  1  head entry present (not empty).
REQ-011: rd_ready  input  1  consumer accepts the head entry.
REQ-012: fifo_count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
REQ-013: full  output  1  fifo_count == DEPTH.
REQ-014: overflow  output  1  sticky flag; a byte was dropped.
REQ-015: overflow_clear  input  1  synchronous clear of overflow.

Function
REQ-016: The block SHALL register data_is_valid once and generate push only on a 0->1 transition, so each receiver frame produces exactly one push.
REQ-017: On push, the block SHALL capture received_data and rx_error from the same cycle as the rising edge, as a 9-bit entry.
REQ-018: Storage SHALL be a DEPTH x 9 register array with write and read pointers of ADDR_WIDTH+1 bits; the pointer MSB SHALL distinguish full from empty.
REQ-019: Pointers SHALL wrap from DEPTH-1 to 0 in the low bits, with the MSB toggling on each wrap.
REQ-020: Output SHALL be first-word-fall-through: rd_data and rd_error are valid whenever rd_valid is 1, with no extra read latency.
REQ-021: A pop SHALL occur when rd_valid and rd_ready are both 1 at a clk edge; rd_ready while empty SHALL have no effect.
REQ-022: Write-to-read latency SHALL be exactly 1 cycle: a pushed byte appears with rd_valid=1 on the cycle after the push edge.
REQ-023: Push while empty with rd_ready=1 SHALL store the byte; no pop SHALL occur that cycle.
REQ-024: Push while full without a pop SHALL drop the byte, leave pointers and contents unchanged, and set overflow on the next edge.
REQ-025: Push while full with a simultaneous pop SHALL be accepted, leaving fifo_count at DEPTH and not setting overflow.
REQ-026: Simultaneous push and pop when not empty and not full SHALL leave fifo_count unchanged.
REQ-027: fifo_count SHALL increment by 1 on push-only, decrement by 1 on pop-only, and never exceed DEPTH or go below 0.
REQ-028: overflow_clear SHALL clear overflow; if an overflow drop occurs in the same cycle, overflow SHALL stay 1 (set wins).
REQ-029: full and rd_valid SHALL be decoded combinationally from the pointers; fifo_count SHALL be consistent with them in every cycle.

Reset
REQ-030: Asserting reset_n=0 SHALL immediately clear both pointers, fifo_count, overflow and the data_is_valid edge register, independent of clk.
REQ-031: Reset SHALL force rd_valid=0 and full=0; rd_data=0 and rd_error=0 are not required, so array contents may stay uncleared.
REQ-032: Reset asserted mid-operation SHALL discard all stored entries, and no push SHALL be generated on the first edge after release if data_is_valid is already high.

Verification
REQ-033: Push 0xA5 (rx_error=0) on an empty FIFO -> next cycle rd_valid=1, rd_data=0xA5, rd_error=0, fifo_count=1; pop -> rd_valid=0.
REQ-034: Hold data_is_valid high for 5 cycles with 0x3C -> exactly one entry stored, fifo_count=1.
REQ-035: Push 0x00..0x0F (DEPTH=16), then 0x10 -> full=1, overflow=1, 0x10 dropped; draining yields 0x00..0x0F in order, and pointers wrap correctly on a second fill.
REQ-036: With the FIFO full, push 0x55 while popping -> count stays 16, overflow stays 0, and 0x55 is read last.
REQ-037: Push 0x81 with rx_error=1 -> rd_error=1 alongside rd_data=0x81; overflow_clear during an overflow drop -> overflow stays 1.
REQ-038: Assert reset_n=0 with 7 entries stored, asynchronously -> rd_valid=0, fifo_count=0, overflow=0 before the next clk edge.
